// File: rtl/dragon_collision_scanner.sv
// Time-multiplexed player/dragon collision checker: captures a snapshot on start, then compares
// one segment per clock from head to tail and reports hit, first-hit index, head hit and hit mask.
module dragon_collision_scanner #(
  parameter int unsigned POS_W      = 8,
  parameter int unsigned MAX_SEGS   = 7,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [POS_W-1:0]          player_pos,
  input  logic [MAX_SEGS*POS_W-1:0] segment_positions,
  input  logic [CNT_W-1:0]          segment_count,
  output logic                      busy,
  output logic                      done,
  output logic                      hit,
  output logic                      hit_head,
  output logic [CNT_W-1:0]          hit_index,
  output logic [MAX_SEGS-1:0]       hit_mask
);

  localparam logic [CNT_W-1:0] MaxSegsC = CNT_W'(MAX_SEGS);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [POS_W-1:0]          snap_player_q, snap_player_d;
  logic [MAX_SEGS*POS_W-1:0] snap_segs_q, snap_segs_d;
  logic [MAX_SEGS-1:0]       acc_mask_q, acc_mask_d;
  logic [CNT_W-1:0]          acc_index_q, acc_index_d;
  logic                      hit_q, hit_d;
  logic                      hit_head_q, hit_head_d;
  logic [CNT_W-1:0]          hit_index_q, hit_index_d;
  logic [MAX_SEGS-1:0]       hit_mask_q, hit_mask_d;

  logic [CNT_W-1:0]    count_clamped;
  logic [POS_W-1:0]    seg_cur;
  logic                match;
  logic                last;
  logic [MAX_SEGS-1:0] mask_upd;
  logic [CNT_W-1:0]    index_upd;

  assign count_clamped = (segment_count > MaxSegsC) ? MaxSegsC : segment_count;
  assign seg_cur       = snap_segs_q[idx_q*POS_W +: POS_W];
  assign match         = (seg_cur == snap_player_q);
  assign last          = (idx_q == count_q - CNT_W'(1));

  always_comb begin
    mask_upd  = acc_mask_q;
    index_upd = acc_index_q;
    if (match) begin
      mask_upd[idx_q] = 1'b1;
      // First match is the one found while no mask bit has been set yet.
      if (acc_mask_q == '0) index_upd = idx_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    count_d       = count_q;
    snap_player_d = snap_player_q;
    snap_segs_d   = snap_segs_q;
    acc_mask_d    = acc_mask_q;
    acc_index_d   = acc_index_q;
    hit_d         = hit_q;
    hit_head_d    = hit_head_q;
    hit_index_d   = hit_index_q;
    hit_mask_d    = hit_mask_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_player_d = player_pos;
          snap_segs_d   = segment_positions;
          count_d       = count_clamped;
          idx_d         = '0;
          acc_mask_d    = '0;
          acc_index_d   = '0;
          if (count_clamped == '0) begin
            // Empty dragon: publish a clean no-hit result straight away.
            state_d     = StDone;
            hit_d       = 1'b0;
            hit_head_d  = 1'b0;
            hit_index_d = '0;
            hit_mask_d  = '0;
          end else begin
            state_d = StScan;
          end
        end
      end
      StScan: begin
        acc_mask_d  = mask_upd;
        acc_index_d = index_upd;
        if ((match && (EARLY_EXIT != 0)) || last) begin
          state_d     = StDone;
          hit_d       = (mask_upd != '0);
          hit_head_d  = mask_upd[0];
          hit_index_d = index_upd;
          hit_mask_d  = mask_upd;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      count_q       <= '0;
      snap_player_q <= '0;
      snap_segs_q   <= '0;
      acc_mask_q    <= '0;
      acc_index_q   <= '0;
      hit_q         <= 1'b0;
      hit_head_q    <= 1'b0;
      hit_index_q   <= '0;
      hit_mask_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      count_q       <= count_d;
      snap_player_q <= snap_player_d;
      snap_segs_q   <= snap_segs_d;
      acc_mask_q    <= acc_mask_d;
      acc_index_q   <= acc_index_d;
      hit_q         <= hit_d;
      hit_head_q    <= hit_head_d;
      hit_index_q   <= hit_index_d;
      hit_mask_q    <= hit_mask_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign hit       = hit_q;
  assign hit_head  = hit_head_q;
  assign hit_index = hit_index_q;
  assign hit_mask  = hit_mask_q;

endmodule

// File: tb/tb_dragon_collision_scanner.sv
// Directed bench for dragon_collision_scanner: one early-exit and one full-scan instance share
// the same stimulus; a vector table plus hand-written reset and busy sequences.
module tb_dragon_collision_scanner;

  localparam int unsigned POS_W    = 8;
  localparam int unsigned MAX_SEGS = 7;
  localparam int unsigned CNT_W    = 3;
  localparam int          WINDOW   = 14;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      start = 1'b0;
  logic [POS_W-1:0]          player_pos = '0;
  logic [MAX_SEGS*POS_W-1:0] segment_positions = '0;
  logic [CNT_W-1:0]          segment_count = '0;

  logic                busy_e, done_e, hit_e, head_e;
  logic [CNT_W-1:0]    index_e;
  logic [MAX_SEGS-1:0] mask_e;
  logic                busy_f, done_f, hit_f, head_f;
  logic [CNT_W-1:0]    index_f;
  logic [MAX_SEGS-1:0] mask_f;

  dragon_collision_scanner #(
    .POS_W(POS_W), .MAX_SEGS(MAX_SEGS), .CNT_W(CNT_W), .EARLY_EXIT(1)
  ) u_early (
    .clk(clk), .reset(reset), .start(start), .player_pos(player_pos),
    .segment_positions(segment_positions), .segment_count(segment_count),
    .busy(busy_e), .done(done_e), .hit(hit_e), .hit_head(head_e),
    .hit_index(index_e), .hit_mask(mask_e)
  );

  dragon_collision_scanner #(
    .POS_W(POS_W), .MAX_SEGS(MAX_SEGS), .CNT_W(CNT_W), .EARLY_EXIT(0)
  ) u_full (
    .clk(clk), .reset(reset), .start(start), .player_pos(player_pos),
    .segment_positions(segment_positions), .segment_count(segment_count),
    .busy(busy_f), .done(done_f), .hit(hit_f), .hit_head(head_f),
    .hit_index(index_f), .hit_mask(mask_f)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [POS_W-1:0]          player;
    logic [MAX_SEGS*POS_W-1:0] segs;
    logic [CNT_W-1:0]          count;
    logic                      hit;
    logic [CNT_W-1:0]          idx;
    logic                      head;
    logic [MAX_SEGS-1:0]       mask_e;
    logic [MAX_SEGS-1:0]       mask_f;
    int                        lat_e;
    int                        lat_f;
  } vec_t;

  vec_t vecs[8];

  // Results of the latest run window
  int                  lat_e, lat_f, nd_e, nd_f;
  logic                c_hit_e, c_head_e, c_hit_f, c_head_f;
  logic [CNT_W-1:0]    c_idx_e, c_idx_f;
  logic [MAX_SEGS-1:0] c_mask_e, c_mask_f;

  // Start in cycle 0; keep start high through cycle hold_until; optionally scramble inputs in cycle 1.
  task automatic run(input logic [POS_W-1:0] p, input logic [MAX_SEGS*POS_W-1:0] s,
                     input logic [CNT_W-1:0] c, input int hold_until, input bit scramble);
    lat_e = -1; lat_f = -1; nd_e = 0; nd_f = 0;
    @(negedge clk);
    player_pos = p; segment_positions = s; segment_count = c; start = 1'b1;
    for (int cyc = 1; cyc <= WINDOW; cyc++) begin
      @(negedge clk);
      if (cyc > hold_until) start = 1'b0;
      if (scramble && cyc == 1) begin
        player_pos = 8'h55;
        segment_positions = ~s;
      end
      if (done_e) begin
        nd_e++;
        if (lat_e < 0) begin
          lat_e = cyc; c_hit_e = hit_e; c_head_e = head_e; c_idx_e = index_e; c_mask_e = mask_e;
        end
      end
      if (done_f) begin
        nd_f++;
        if (lat_f < 0) begin
          lat_f = cyc; c_hit_f = hit_f; c_head_f = head_f; c_idx_f = index_f; c_mask_f = mask_f;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    //                 player  segs                count hit idx head mask_e       mask_f       le lf
    vecs[0] = '{8'h55, 56'h16151413121110, 3'd7, 1'b0, 3'd0, 1'b0, 7'b0000000, 7'b0000000, 8, 8};
    vecs[1] = '{8'h12, 56'h16121413121110, 3'd7, 1'b1, 3'd2, 1'b0, 7'b0000100, 7'b0100100, 4, 8};
    vecs[2] = '{8'h12, 56'h16121514131110, 3'd3, 1'b0, 3'd0, 1'b0, 7'b0000000, 7'b0000000, 4, 4};
    vecs[3] = '{8'h12, 56'h16121413121110, 3'd0, 1'b0, 3'd0, 1'b0, 7'b0000000, 7'b0000000, 1, 1};
    vecs[4] = '{8'h10, 56'h16151413121110, 3'd7, 1'b1, 3'd0, 1'b1, 7'b0000001, 7'b0000001, 2, 8};
    vecs[5] = '{8'h16, 56'h16151413121110, 3'd7, 1'b1, 3'd6, 1'b0, 7'b1000000, 7'b1000000, 8, 8};
    vecs[6] = '{8'hAA, 56'hAAAAAAAAAAAAAA, 3'd4, 1'b1, 3'd0, 1'b1, 7'b0000001, 7'b0001111, 2, 5};
    vecs[7] = '{8'h11, 56'h16151413121110, 3'd1, 1'b0, 3'd0, 1'b0, 7'b0000000, 7'b0000000, 2, 2};

    // Reset state
    #2;
    check("reset busy_e", busy_e, 0);
    check("reset outs_e", {done_e, hit_e, head_e, index_e, mask_e}, 0);
    check("reset outs_f", {busy_f, done_f, hit_f, head_f, index_f, mask_f}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle after reset", {busy_e, busy_f}, 0);

    for (int i = 0; i < 8; i++) begin
      run(vecs[i].player, vecs[i].segs, vecs[i].count, 0, 1'b0);
      check($sformatf("v%0d lat_e", i), lat_e, vecs[i].lat_e);
      check($sformatf("v%0d lat_f", i), lat_f, vecs[i].lat_f);
      check($sformatf("v%0d ndone", i), {nd_e[7:0], nd_f[7:0]}, {8'd1, 8'd1});
      check($sformatf("v%0d res_e", i), {c_hit_e, c_head_e, c_idx_e, c_mask_e},
            {vecs[i].hit, vecs[i].head, vecs[i].idx, vecs[i].mask_e});
      check($sformatf("v%0d res_f", i), {c_hit_f, c_head_f, c_idx_f, c_mask_f},
            {vecs[i].hit, vecs[i].head, vecs[i].idx, vecs[i].mask_f});
      // Results hold while idle
      check($sformatf("v%0d hold_f", i), {busy_f, hit_f, head_f, index_f, mask_f},
            {1'b0, vecs[i].hit, vecs[i].head, vecs[i].idx, vecs[i].mask_f});
    end

    // Busy: start held through the full DUT's DONE cycle, inputs scrambled mid-scan
    run(8'h12, 56'h16121413121110, 3'd7, 8, 1'b1);
    check("busy lat_f", lat_f, 8);
    check("busy ndone_f", nd_f, 1);
    check("busy res_f", {c_hit_f, c_idx_f, c_mask_f}, {1'b1, 3'd2, 7'b0100100});
    check("busy res_e", {c_hit_e, c_idx_e, c_mask_e}, {1'b1, 3'd2, 7'b0000100});
    repeat (10) @(negedge clk);

    // Reset mid-scan after a hit left non-zero results
    run(8'h10, 56'h16151413121110, 3'd7, 0, 1'b0);
    @(negedge clk);
    player_pos = 8'h55; segment_positions = 56'h16151413121110; segment_count = 3'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset outs_e", {busy_e, done_e, hit_e, head_e, index_e, mask_e}, 0);
    check("midreset outs_f", {busy_f, done_f, hit_f, head_f, index_f, mask_f}, 0);
    @(negedge clk);
    reset = 1'b1;
    nd_f = 0; nd_e = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (done_e || busy_e) nd_e++;
      if (done_f || busy_f) nd_f++;
    end
    check("midreset no activity", {nd_e[7:0], nd_f[7:0]}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
